// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_port
//  Description : Load/store initiator for one byte-lane memory port. Splits
//                word-crossing accesses into two beats and realigns loads.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_mem_port #(
    parameter  int MEM_SIZE = 8192,
    localparam int ADDR_W   = $clog2(MEM_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_data_en,
    output logic              mem_write_en,
    input  logic [31:0]       mem_rdata
);

    localparam int WORD_W = ADDR_W - 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEAT0 = 3'd1,
        S_BEAT1 = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [1:0]          r_off;
    logic                r_split;
    logic [WORD_W-1:0]   r_word;
    logic [3:0]          r_en_hi;
    logic [31:0]         r_wdata_hi;
    logic [31:0]         r_beat0;

    logic                w_accept;
    logic                w_err;
    logic                w_split;
    logic [1:0]          w_off;
    logic [WORD_W-1:0]   w_word;
    logic [WORD_W-1:0]   w_word_next;
    logic [3:0]          w_mask;
    logic [2:0]          w_bytes;
    logic [7:0]          w_en_wide;
    logic [63:0]         w_wdata_wide;
    logic [63:0]         w_ld_cat;
    logic [31:0]         w_ld_low;
    logic [31:0]         w_ld_data;

    assign w_accept    = req_valid && req_ready;
    assign w_word_next = r_word + WORD_W'(1);

    // Request decode: the upper nibble/word of the shifted values is beat 1.
    always_comb begin
        w_off   = req_addr[1:0];
        w_word  = req_addr[ADDR_W-1:2];
        w_mask  = 4'b0001;
        w_bytes = 3'd1;
        case (req_size)
            2'b01: begin
                w_mask  = 4'b0011;
                w_bytes = 3'd2;
            end
            2'b10: begin
                w_mask  = 4'b1111;
                w_bytes = 3'd4;
            end
            default: ;
        endcase
        w_err        = (req_size == 2'b11) || ((req_addr >> ADDR_W) != 32'd0);
        w_split      = (({1'b0, w_off} + w_bytes) > 3'd4);
        w_en_wide    = {4'b0000, w_mask} << w_off;
        w_wdata_wide = {32'd0, req_wdata} << {w_off, 3'b000};
    end

    always_comb begin
        w_ld_cat = r_split ? {mem_rdata, r_beat0} : {32'd0, mem_rdata};
        w_ld_low = 32'(w_ld_cat >> {r_off, 3'b000});
        case (r_size)
            2'b00:   w_ld_data = r_unsigned ? {24'd0, w_ld_low[7:0]}
                                            : {{24{w_ld_low[7]}}, w_ld_low[7:0]};
            2'b01:   w_ld_data = r_unsigned ? {16'd0, w_ld_low[15:0]}
                                            : {{16{w_ld_low[15]}}, w_ld_low[15:0]};
            default: w_ld_data = w_ld_low;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_off        <= 2'b00;
            r_split      <= 1'b0;
            r_word       <= '0;
            r_en_hi      <= 4'b0000;
            r_wdata_hi   <= 32'd0;
            r_beat0      <= 32'd0;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= 32'd0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
            mem_data_en  <= 4'b0000;
            mem_write_en <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            case (r_state)
                // Ready is held in the response cycle, so RESP accepts like IDLE.
                S_IDLE, S_RESP: begin
                    mem_write_en <= 1'b0;
                    mem_data_en  <= 4'b0000;
                    req_ready    <= 1'b1;
                    r_state      <= S_IDLE;
                    if (w_accept) begin
                        if (w_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            r_state    <= S_RESP;
                        end else begin
                            r_we         <= req_we;
                            r_size       <= req_size;
                            r_unsigned   <= req_unsigned;
                            r_off        <= w_off;
                            r_split      <= w_split;
                            r_word       <= w_word;
                            r_en_hi      <= w_en_wide[7:4];
                            r_wdata_hi   <= w_wdata_wide[63:32];
                            req_ready    <= 1'b0;
                            mem_addr     <= {w_word, 2'b00};
                            mem_data_en  <= w_en_wide[3:0];
                            mem_wdata    <= w_wdata_wide[31:0];
                            mem_write_en <= req_we;
                            r_state      <= S_BEAT0;
                        end
                    end
                end
                S_BEAT0: begin
                    if (r_split) begin
                        mem_addr     <= {w_word_next, 2'b00};
                        mem_data_en  <= r_en_hi;
                        mem_wdata    <= r_wdata_hi;
                        mem_write_en <= r_we;
                        r_state      <= S_BEAT1;
                    end else begin
                        mem_write_en <= 1'b0;
                        mem_data_en  <= 4'b0000;
                        if (r_we) begin
                            resp_valid <= 1'b1;
                            req_ready  <= 1'b1;
                            r_state    <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_BEAT1: begin
                    mem_write_en <= 1'b0;
                    mem_data_en  <= 4'b0000;
                    if (r_we) begin
                        resp_valid <= 1'b1;
                        req_ready  <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        // Read data for beat 0 arrives while beat 1 is on the bus.
                        r_beat0 <= mem_rdata;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= w_ld_data;
                    req_ready  <= 1'b1;
                    r_state    <= S_RESP;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_mem_port
//  Description : Scoreboard bench for lsu_mem_port with a byte-lane memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_mem_port;

    localparam int MEM_SIZE = 8192;
    localparam int AW       = $clog2(MEM_SIZE);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_addr = 32'd0;
    logic [31:0]   req_wdata = 32'd0;
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_data_en;
    logic          mem_write_en;
    logic [31:0]   mem_rdata;

    lsu_mem_port #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_data_en  (mem_data_en),
        .mem_write_en (mem_write_en),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte-lane memory, one-cycle read latency.
    logic [31:0] mem [0:MEM_SIZE/4-1];
    always @(posedge clk) begin
        if (mem_write_en)
            for (int b = 0; b < 4; b++)
                if (mem_data_en[b]) mem[mem_addr[AW-1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= mem[mem_addr[AW-1:2]];
    end

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [3:0]  en;
        logic        we;
        logic [31:0] wdata;
        logic        chk_wd;
    } beat_t;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    beat_t beat_q[$];
    resp_t resp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT drives a beat or a response.
    always @(negedge clk) begin
        beat_t b;
        resp_t r;
        if (rst_n) begin
            if (mem_data_en != 4'b0000) begin
                if (beat_q.size() == 0) flag("unexpected_beat");
                else begin
                    b = beat_q.pop_front();
                    check("beat_cycle", cyc, b.cyc);
                    check("beat_addr", 32'(mem_addr), b.addr);
                    check("beat_en", 32'(mem_data_en), 32'(b.en));
                    check("beat_we", 32'(mem_write_en), 32'(b.we));
                    if (b.chk_wd) check("beat_wdata", mem_wdata, b.wdata);
                end
            end else if (mem_write_en) begin
                flag("write_without_enables");
            end
            if (resp_valid) begin
                if (resp_q.size() == 0) flag("unexpected_resp");
                else begin
                    r = resp_q.pop_front();
                    check("resp_cycle", cyc, r.cyc);
                    check("resp_err", 32'(resp_err), 32'(r.err));
                    check("resp_rdata", resp_rdata, r.rdata);
                    check("resp_ready", 32'(req_ready), 32'd1);
                end
            end
        end
    end

    // lat = cycles from accept to response (0: no response expected).
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int lat, input logic err, input logic [31:0] rdata,
                         input int nb,
                         input logic [31:0] a0, input logic [3:0] e0, input logic [31:0] w0,
                         input logic [31:0] a1, input logic [3:0] e1, input logic [31:0] w1);
        int    k;
        beat_t b;
        resp_t r;
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            flag("req_ready_timeout");
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        if (nb >= 1) begin
            b.cyc = cyc + 1; b.addr = a0; b.en = e0; b.we = we; b.wdata = w0; b.chk_wd = we;
            beat_q.push_back(b);
        end
        if (nb >= 2) begin
            b.cyc = cyc + 2; b.addr = a1; b.en = e1; b.we = we; b.wdata = w1; b.chk_wd = we;
            beat_q.push_back(b);
        end
        if (lat > 0) begin
            r.cyc = cyc + lat; r.err = err; r.rdata = rdata;
            resp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((beat_q.size() != 0 || resp_q.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("beat_q_drained", beat_q.size(), 32'd0);
        check("resp_q_drained", resp_q.size(), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_data_en", 32'(mem_data_en), 32'd0);
        check("rst_mem_write_en", 32'(mem_write_en), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        #1 check("ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("ready_after_release", 32'(req_ready), 32'd1);

        // Aligned word store/load
        issue(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 2, 0, 32'h0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0);
        issue(0, 2'b10, 0, 32'h100, 32'h0, 3, 0, 32'hDEADBEEF, 1, 32'h100, 4'hF, 0, 0, 0, 0);
        // Byte store, signed and unsigned loads
        issue(1, 2'b00, 0, 32'h103, 32'h80, 2, 0, 32'h0, 1, 32'h100, 4'h8, 32'h80000000, 0, 0, 0);
        issue(0, 2'b00, 0, 32'h103, 32'h0, 3, 0, 32'hFFFFFF80, 1, 32'h100, 4'h8, 0, 0, 0, 0);
        issue(0, 2'b00, 1, 32'h103, 32'h0, 3, 0, 32'h00000080, 1, 32'h100, 4'h8, 0, 0, 0, 0);
        // Misaligned word store/load (split)
        issue(1, 2'b10, 0, 32'h102, 32'h11223344, 3, 0, 32'h0, 2,
              32'h100, 4'hC, 32'h33440000, 32'h104, 4'h3, 32'h00001122);
        issue(0, 2'b10, 0, 32'h102, 32'h0, 4, 0, 32'h11223344, 2, 32'h100, 4'hC, 0, 32'h104, 4'h3, 0);
        // Memory now: 0x100 = 3344BEEF, 0x104 = 00001122
        issue(0, 2'b01, 0, 32'h100, 32'h0, 3, 0, 32'hFFFFBEEF, 1, 32'h100, 4'h3, 0, 0, 0, 0);
        issue(0, 2'b00, 1, 32'h101, 32'h0, 3, 0, 32'h000000BE, 1, 32'h100, 4'h2, 0, 0, 0, 0);
        issue(0, 2'b10, 1, 32'h101, 32'h0, 4, 0, 32'h223344BE, 2, 32'h100, 4'hE, 0, 32'h104, 4'h1, 0);
        // Halfword wrapping past the top of memory
        issue(1, 2'b01, 0, 32'h1FFF, 32'h0000A55A, 3, 0, 32'h0, 2,
              32'h1FFC, 4'h8, 32'h5A000000, 32'h0, 4'h1, 32'h000000A5);
        issue(0, 2'b01, 0, 32'h1FFF, 32'h0, 4, 0, 32'hFFFFA55A, 2, 32'h1FFC, 4'h8, 0, 32'h0, 4'h1, 0);
        // Errors: illegal size, out-of-range addresses
        issue(1, 2'b11, 0, 32'h100, 32'h12345678, 1, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        issue(0, 2'b10, 0, 32'h2000, 32'h0, 1, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        issue(1, 2'b00, 1, 32'h80000000, 32'hFF, 1, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        issue(0, 2'b10, 0, 32'h100, 32'h0, 3, 0, 32'h3344BEEF, 1, 32'h100, 4'hF, 0, 0, 0, 0);
        drain();

        // Reset during C2 of a split load: no response may follow
        issue(0, 2'b10, 0, 32'h102, 32'h0, 0, 0, 32'h0, 2, 32'h100, 4'hC, 0, 32'h104, 4'h3, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        repeat (3) @(negedge clk);
        check("ready_held_in_reset", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1 check("ready_before_edge2", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("ready_after_release2", 32'(req_ready), 32'd1);
        repeat (4) @(negedge clk);
        issue(0, 2'b10, 0, 32'h100, 32'h0, 3, 0, 32'h3344BEEF, 1, 32'h100, 4'hF, 0, 0, 0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator that drives one port of the dual-port byte-lane main memory on behalf of the core's execute stage. It accepts one byte, halfword or word request at a time. It generates the word address, byte enables and lane-shifted write data, and splits accesses that cross a word boundary into two memory beats. For loads, it realigns the one-cycle-latency read data and sign- or zero-extends the result.

## Interface
- MEM_SIZE, 8192, memory size in bytes (power of two, ≥ 8); ADDR_W = $clog2(MEM_SIZE) is derived locally
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  unit idle, can accept
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse, no backpressure
- resp_err  out  1  qualifies resp_valid: illegal size or out-of-range address
- resp_rdata  out  32  load result, 0 for stores and errors
- mem_addr  out  ADDR_W  byte address to memory, bits [1:0] always 0
- mem_wdata  out  32  lane-aligned write data
- mem_data_en  out  4  byte-lane enables, bit i = bits [8i+7:8i]
- mem_write_en  out  1  write strobe
- mem_rdata  in  32  memory read data, valid the cycle after a read beat

## Operation
- States: IDLE, BEAT0, BEAT1, WAIT, RESP.
- All outputs are registered.
- Reset values: req_ready 0, resp_valid 0, resp_err 0, resp_rdata 0, mem_addr 0, mem_wdata 0, mem_data_en 0, mem_write_en 0. req_ready rises on the first edge after rst_n deasserts.
- Accept: req_valid && req_ready in cycle C0. Request fields are latched and req_ready drops.
- Decode: offset o = req_addr[1:0], word w = req_addr[ADDR_W-1:2]. Base mask is 0001, 0011 or 1111 for byte, half and word.
- Split condition: o + bytes > 4, i.e. half with o=3, or word with o≠0.
- Beat 0 (word w):
  - mem_data_en = (mask << o) truncated to 4 bits
  - mem_wdata = req_wdata << 8o
- Beat 1 (word (w+1) mod MEM_SIZE/4, wrapping to word 0 at the top):
  - mem_data_en = mask >> (4−o)
  - mem_wdata = req_wdata >> 8(4−o)
- Load beats drive mem_write_en=0 with the same enables. The memory ignores enables on reads.
- Outside beats, mem_write_en=0 and mem_data_en=0; mem_addr holds its value.
- Load data path:
  - The 64-bit concatenation {beat1_data, beat0_data} is shifted right by 8o. beat1_data is 0 when there is no split.
  - The low 8, 16 or 32 bits are taken and extended per req_unsigned.
- Error: size 11, or req_addr[31:ADDR_W] ≠ 0. No memory beat is issued; resp_valid=1, resp_err=1, resp_rdata=0.
- resp_err=0 on every successful response. resp_rdata returns to 0 in non-response cycles.

## Timing
All latencies are counted from the accept cycle C0.
- Error: resp_valid in C1.
- Aligned store: beat 0 in C1; resp_valid in C2.
- Split store: beats in C1 and C2; resp_valid in C3.
- Aligned load: beat in C1; mem_rdata sampled in C2; resp_valid in C3.
- Split load: beats in C1 and C2; data sampled in C2 and C3; resp_valid in C4.
- req_ready is high in the resp_valid cycle, so back-to-back requests are accepted there. Throughput is one aligned load per 3 cycles.
- Requests offered while req_ready=0 are ignored. They are not queued.
- Reset mid-operation: the request is abandoned and no response is issued. A split store may leave beat 0 written; this is accepted behaviour.

## Test plan
- Aligned word store 0x0000_0100 ← 0xDEADBEEF, then load word → C1 en=1111, wdata=0xDEADBEEF, we=1; load resp_rdata=0xDEADBEEF in C3; req_ready high in each response cycle.
- Byte store 0x103 ← 0x80 → en=1000, wdata=0x8000_0000; signed byte load 0x103 → 0xFFFF_FF80; unsigned → 0x0000_0080.
- Misaligned word store 0x102 ← 0x11223344 → beat 0 addr 0x100, en=1100, wdata=0x3344_0000; beat 1 addr 0x104, en=0011, wdata=0x0000_1122; resp in C3; load 0x102 returns 0x11223344 in C4.
- Halfword at 0x1FFF (MEM_SIZE=8192), store 0xA55A → beat 0 addr 0x1FFC, en=1000; beat 1 addr 0x0000, en=0001; signed load returns 0xFFFF_A55A.
- req_size=11, then req_addr=0x0000_2000 → resp_valid=1, resp_err=1, rdata=0 in C1; mem_write_en and mem_data_en stay 0 throughout.
- rst_n low during C2 of a split load → all outputs at reset values immediately; no resp_valid; req_ready=1 one edge after release.
